// File: rtl/down_counter_pkg.sv
// down_counter_pkg: shared state encoding and default width for the loadable down-counter
package down_counter_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/down_cnt_bit.sv
// down_cnt_bit: single-bit loadable toggle cell forming one link of the borrow chain
module down_cnt_bit (
    input  logic clk,
    input  logic res,
    input  logic ld,
    input  logic d,
    input  logic bi,
    output logic q,
    output logic bo
);

    // The borrow continues only through a bit that is already 0
    assign bo = bi & ~q;

    // Load takes priority over toggling on an incoming borrow
    always_ff @(posedge clk) begin
        if (!res)
            q <= 1'b0;
        else if (ld)
            q <= d;
        else if (bi)
            q <= ~q;
    end

endmodule

// File: rtl/down_counter_hex.sv
// down_counter_hex: loadable down-counter/timer with terminal-count pulse and optional auto-reload
module down_counter_hex
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             auto,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             zero
);

    state_t           state;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] cell_d;
    logic [WIDTH-1:0] bi;
    logic [WIDTH-1:0] bo;
    logic             step;
    logic             hit;
    logic             reld;
    logic             cell_ld;
    logic             bo_unused;

    // A count step happens only in RUN with en high and no load/abort; q != 0 guards against wrapping
    assign step    = (state == ST_RUN) & en & ~load & ~abort & (q != '0);
    assign hit     = step & (q == WIDTH'(1));
    assign reld    = hit & auto;
    assign cell_ld = load | reld;
    assign cell_d  = load ? din : reload;
    assign zero    = (q == '0);

    // On an auto-reload the cells are loaded, so the borrow chain must stay quiet
    assign bi        = {bo[WIDTH-2:0], step & ~reld};
    assign bo_unused = bo[WIDTH-1];

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            down_cnt_bit u_bit (
                .clk (clk),
                .res (res),
                .ld  (cell_ld),
                .d   (cell_d[i]),
                .bi  (bi[i]),
                .q   (q[i]),
                .bo  (bo[i])
            );
        end
    endgenerate

    // Control FSM with reload register and registered busy/tc outputs
    always_ff @(posedge clk) begin
        if (!res) begin
            state  <= ST_IDLE;
            reload <= '0;
            busy   <= 1'b0;
            tc     <= 1'b0;
        end else if (load) begin
            reload <= din;
            state  <= (din != '0) ? ST_RUN : ST_IDLE;
            busy   <= (din != '0);
            tc     <= 1'b0;
        end else if (abort) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            tc     <= 1'b0;
        end else begin
            tc <= hit;
            if (hit && !auto) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_down_counter_hex.sv
// tb_down_counter_hex: directed and randomized checks of down_counter_hex against a behavioural model
module tb_down_counter_hex;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         res = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] din = '0;
    logic         en = 1'b0;
    logic         auto = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] q;
    logic         busy;
    logic         tc;
    logic         zero;

    int tests = 0;
    int fails = 0;

    int m_q = 0;
    int m_rel = 0;
    bit m_run = 0;
    bit m_tc = 0;
    int tc_count = 0;

    down_counter_hex #(.WIDTH(W)) dut (
        .clk   (clk),
        .res   (res),
        .load  (load),
        .din   (din),
        .en    (en),
        .auto  (auto),
        .abort (abort),
        .q     (q),
        .busy  (busy),
        .tc    (tc),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: the counter's rules written as plain integer arithmetic
    task automatic model_edge();
        if (!res) begin
            m_q = 0; m_rel = 0; m_run = 0; m_tc = 0;
        end else if (load) begin
            m_q = int'(din); m_rel = int'(din); m_run = (din != 0); m_tc = 0;
        end else if (abort) begin
            m_run = 0; m_tc = 0;
        end else if (m_run && en) begin
            if (m_q == 1) begin
                m_tc = 1;
                if (auto) m_q = m_rel;
                else begin m_q = 0; m_run = 0; end
            end else begin
                m_q = m_q - 1; m_tc = 0;
            end
        end else begin
            m_tc = 0;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".q"}, int'(q), m_q);
        chk({tag, ".busy"}, int'(busy), int'(m_run));
        chk({tag, ".tc"}, int'(tc), int'(m_tc));
        chk({tag, ".zero"}, int'(zero), int'(m_q == 0));
        if (tc) tc_count++;
    endtask

    task automatic drive(input bit r, input bit l, input int d, input bit e, input bit a, input bit ab);
        res = r; load = l; din = W'(d); en = e; auto = a; abort = ab;
    endtask

    initial begin
        // Reset held with load asserted must win
        drive(0, 1, 4'hA, 1, 0, 0);
        step("rst0");
        step("rst1");
        chk("rst.q_const", int'(q), 0);
        drive(1, 0, 0, 1, 0, 0);
        step("rst_rel");
        chk("rst.busy_const", int'(busy), 0);

        // One-shot countdown of 5
        drive(1, 1, 5, 1, 0, 0);
        step("os_ld");
        chk("os.q_load", int'(q), 5);
        load = 0;
        tc_count = 0;
        for (int i = 0; i < 8; i++) step("os");
        chk("os.q_final", int'(q), 0);
        chk("os.tc_pulses", tc_count, 1);

        // Auto-reload period of 3
        drive(1, 1, 3, 1, 1, 0);
        step("ar_ld");
        load = 0;
        tc_count = 0;
        for (int i = 0; i < 9; i++) step("ar");
        chk("ar.tc_pulses", tc_count, 3);
        chk("ar.busy_const", int'(busy), 1);

        // Enable gating through a full borrow ripple from 8
        drive(1, 1, 8, 0, 0, 0);
        step("eg_ld");
        load = 0;
        for (int i = 0; i < 8; i++) begin
            en = i[0];
            step("eg");
        end
        chk("eg.q_const", int'(q), 4);

        // Abort at 6, en ignored in IDLE, then restart with 2
        drive(1, 1, 9, 1, 0, 0);
        step("ab_ld");
        load = 0;
        step("ab"); step("ab"); step("ab");
        abort = 1;
        step("ab_abort");
        abort = 0;
        step("ab_idle"); step("ab_idle");
        chk("ab.q_held", int'(q), 6);
        chk("ab.busy_idle", int'(busy), 0);
        drive(1, 1, 2, 1, 0, 0);
        step("rs_ld");
        load = 0;
        step("rs"); step("rs");
        chk("rs.tc_const", int'(tc), 1);

        // Load colliding with terminal count, then load of 0
        drive(1, 1, 2, 1, 0, 0);
        step("cl_ld");
        load = 0;
        step("cl");
        chk("cl.q_one", int'(q), 1);
        drive(1, 1, 7, 1, 0, 0);
        step("cl_hit");
        chk("cl.q_seven", int'(q), 7);
        chk("cl.no_tc", int'(tc), 0);
        drive(1, 1, 0, 1, 1, 0);
        step("cl_zero");
        load = 0;
        tc_count = 0;
        for (int i = 0; i < 3; i++) step("cl_idle");
        chk("cl.zero_no_tc", tc_count, 0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            res   = ($urandom_range(0, 59) != 0);
            load  = ($urandom_range(0, 9) == 0);
            din   = W'($urandom_range(0, 15));
            en    = ($urandom_range(0, 3) != 0);
            abort = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) == 0) auto = $urandom_range(0, 1) != 0;
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
